// File: rtl/trace_pkg.sv
// Shared types for the register-bank trace path: record layout, word indices, serializer states.
package trace_pkg;

  localparam int NREG = 8;
  localparam int RW   = 16;
  localparam int PCW  = 16;

  localparam int         REC_WORDS = 9;
  localparam logic [3:0] WORD_PC   = 4'd0;
  localparam logic [3:0] WORD_R7   = 4'(REC_WORDS - 1);

  typedef struct packed {
    logic [PCW-1:0]     pc;
    logic [NREG*RW-1:0] regs;
  } trace_rec_t;

  typedef enum logic {IDLE, SEND} ser_state_t;

  // Word 0 is the PC, words 1..NREG are r0..r7.
  function automatic logic [RW-1:0] rec_word(input trace_rec_t rec, input logic [3:0] idx);
    logic [RW-1:0] w;
    w = rec.pc;
    for (int k = 0; k < NREG; k++) begin
      if (idx == 4'(k + 1)) w = rec.regs[k*RW +: RW];
    end
    return w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO, 1-cycle write-to-visible latency.
// A push while full is taken only when a pop completes in the same cycle; otherwise it is ignored.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  trace_rec_t               din,
  input  logic                     pop,
  output trace_rec_t               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  trace_rec_t     mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/regbank_trace_unit.sv
// Snapshots PC + register bank on each PC change and streams records as 16-bit words.
// First word valid 2 cycles after capture; out_ready low holds the word, full FIFO drops records.
module regbank_trace_unit
  import trace_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_LIMIT = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PCW-1:0]      pc_in,
  input  logic [NREG*RW-1:0]  regbank_in,
  input  logic                trace_en,
  output logic [RW-1:0]       out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                overflow,
  output logic [7:0]          drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  ser_state_t      state;
  logic [3:0]      idx;
  logic [PCW-1:0]  pc_prev;
  logic            first;

  trace_rec_t      head;
  trace_rec_t      din;
  logic            full;
  logic            empty;
  logic [AW:0]     level;

  logic            cap;
  logic            hs;
  logic            pop;
  logic            push_ok;
  logic            drop;
  logic            more_after_pop;

  assign cap     = trace_en && (pc_in < PCW'(PC_LIMIT)) && (first || (pc_in != pc_prev));
  assign hs      = out_valid && out_ready;
  assign pop     = hs && (idx == WORD_R7);
  assign push_ok = cap && (!full || pop);
  assign drop    = cap && full && !pop;
  // After popping the last word the stream continues if anything remains, including a same-cycle push.
  assign more_after_pop = (level > (AW+1)'(1)) || push_ok;

  assign din      = '{pc: pc_in, regs: regbank_in};
  assign out_data = out_valid ? rec_word(head, idx) : '0;

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cap),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_prev  <= '0;
      first    <= 1'b1;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      pc_prev <= pc_in;
      if (cap) first <= 1'b0;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= WORD_PC;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state     <= SEND;
            idx       <= WORD_PC;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end
        end
        SEND: begin
          if (hs) begin
            if (idx == WORD_R7) begin
              idx      <= WORD_PC;
              out_last <= 1'b0;
              if (!more_after_pop) begin
                state     <= IDLE;
                out_valid <= 1'b0;
              end
            end else begin
              idx      <= idx + 4'd1;
              out_last <= (idx == WORD_R7 - 4'd1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_trace_unit.sv
// Directed bench for regbank_trace_unit: capture, streaming, stall/overflow, full+pop, filtering, reset.
module tb_regbank_trace_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  pc_in;
  logic [15:0]  r1_val;
  logic [127:0] regbank_in;
  logic         trace_en;
  logic         out_ready;
  logic [15:0]  out_data;
  logic         out_valid;
  logic         out_last;
  logic         overflow;
  logic [7:0]   drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign regbank_in = {16'h0107, 16'h0106, 16'h0105, 16'h0104,
                       16'h0103, 16'h0102, r1_val,   16'h0100};

  regbank_trace_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .regbank_in (regbank_in),
    .trace_en   (trace_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Consume one 9-word record with out_ready held high; optionally change PC during the r7 word.
  task automatic recv_rec(input string tag, input logic [15:0] pc, input logic [15:0] r1, input int inj_pc);
    logic [15:0] e;
    int n;
    for (int i = 0; i < 9; i++) begin
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk($sformatf("%s w%0d valid", tag, i), {31'd0, out_valid}, 32'd1);
      if (i == 0)      e = pc;
      else if (i == 2) e = r1;
      else             e = 16'(16'h0100 + i - 1);
      chk($sformatf("%s w%0d data", tag, i), {16'd0, out_data}, {16'd0, e});
      chk($sformatf("%s w%0d last", tag, i), {31'd0, out_last}, {31'd0, (i == 8)});
      if (i == 8 && inj_pc >= 0) pc_in = 16'(inj_pc);
      tick();
    end
  endtask

  initial begin
    rst       = 1'b1;
    pc_in     = 16'd0;
    r1_val    = 16'h0101;
    trace_en  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst valid",    {31'd0, out_valid}, 32'd0);
    chk("rst last",     {31'd0, out_last},  32'd0);
    chk("rst data",     {16'd0, out_data},  32'd0);
    chk("rst overflow", {31'd0, overflow},  32'd0);
    chk("rst drop_cnt", {24'd0, drop_cnt},  32'd0);
    rst = 1'b0;

    // PC 0 -> 4 -> 8, consumer stalled while capturing so every word is observed
    trace_en  = 1'b1;
    out_ready = 1'b0;
    pc_in     = 16'd0;
    tick();
    chk("lat valid 1cyc", {31'd0, out_valid}, 32'd0);
    pc_in  = 16'd4;
    r1_val = 16'd5;
    tick();
    chk("lat valid 2cyc", {31'd0, out_valid}, 32'd1);
    chk("lat first word", {16'd0, out_data},  32'd0);
    chk("lat first last", {31'd0, out_last},  32'd0);
    pc_in  = 16'd8;
    r1_val = 16'h0101;
    tick();
    out_ready = 1'b1;
    recv_rec("A0", 16'd0, 16'h0101, -1);
    recv_rec("A4", 16'd4, 16'd5,    -1);
    recv_rec("A8", 16'd8, 16'h0101, -1);

    // PC held at 8: nothing further
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold8 idle %0d", i), {31'd0, out_valid}, 32'd0);
      tick();
    end
    chk("A overflow", {31'd0, overflow}, 32'd0);

    // six PC changes while stalled: four kept, two dropped
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pc_in = 16'(10 + i);
      tick();
    end
    chk("stall overflow", {31'd0, overflow}, 32'd1);
    chk("stall drop_cnt", {24'd0, drop_cnt}, 32'd2);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("stall valid %0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall data %0d", i),  {16'd0, out_data},  32'd10);
      tick();
    end

    // drain, with a new PC arriving in the same cycle as the r7 handshake of a full FIFO
    out_ready = 1'b1;
    recv_rec("S10", 16'd10, 16'h0101, 20);
    chk("fullpop drop_cnt", {24'd0, drop_cnt}, 32'd2);
    recv_rec("S11", 16'd11, 16'h0101, -1);
    recv_rec("S12", 16'd12, 16'h0101, -1);
    recv_rec("S13", 16'd13, 16'h0101, -1);
    recv_rec("S20", 16'd20, 16'h0101, -1);
    chk("drain drop_cnt", {24'd0, drop_cnt}, 32'd2);
    chk("drain valid",    {31'd0, out_valid}, 32'd0);

    // PC at or above the limit, then tracing disabled: no captures
    pc_in = 16'd24; tick();
    pc_in = 16'd25; tick();
    trace_en = 1'b0;
    pc_in = 16'd1; tick();
    pc_in = 16'd2; tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("filter idle %0d", i), {31'd0, out_valid}, 32'd0);
      tick();
    end

    // reset in the middle of a record
    trace_en = 1'b1;
    pc_in    = 16'd5;
    tick();
    tick();
    chk("midrst valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("midrst idx4 word", {16'd0, out_data}, 32'h0103);
    rst = 1'b1;
    #1;
    chk("midrst async valid", {31'd0, out_valid}, 32'd0);
    chk("midrst async data",  {16'd0, out_data},  32'd0);
    pc_in = 16'd6;
    tick();
    rst = 1'b0;
    chk("postrst valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("postrst no residual", {31'd0, out_valid}, 32'd0);
    recv_rec("R6", 16'd6, 16'h0101, -1);
    chk("postrst drop_cnt", {24'd0, drop_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
